// File: rtl/fsm_pkg.sv
// Shared FSM encodings for the sequencing blocks.
// State encodings are kept as plain 2-bit constants so they stay compatible with
// the older FSM blocks that also use this package.
package fsm_pkg;

   localparam int unsigned STATE_WIDTH = 2;

   localparam logic [1:0] STATE_IDLE = 2'b00;
   localparam logic [1:0] STATE_RUN  = 2'b01;
   localparam logic [1:0] STATE_DONE = 2'b10;

endpackage : fsm_pkg

// File: rtl/fsm_run_timer_if.sv
// Start/status bundle for fsm_run_timer.
// Optional macro FSM_ABORT_EN adds the i_abort / o_aborted pair.
interface fsm_run_timer_if #(
   parameter int unsigned CNT_WIDTH = 8
);

   logic                 i_isRun;
   logic [CNT_WIDTH-1:0] i_num_cnt;
   logic                 o_idle;
   logic                 o_running;
   logic                 o_done;
   logic [CNT_WIDTH-1:0] o_cnt_val;
`ifdef FSM_ABORT_EN
   logic                 i_abort;
   logic                 o_aborted;
`endif

   // Timer side: consumes the request, produces status
   modport slave (
`ifdef FSM_ABORT_EN
      input  i_abort,
      output o_aborted,
`endif
      input  i_isRun,
      input  i_num_cnt,
      output o_idle,
      output o_running,
      output o_done,
      output o_cnt_val
   );

   // Requester side: issues starts, observes status
   modport master (
`ifdef FSM_ABORT_EN
      output i_abort,
      input  o_aborted,
`endif
      output i_isRun,
      output i_num_cnt,
      input  o_idle,
      input  o_running,
      input  o_done,
      input  o_cnt_val
   );

endinterface : fsm_run_timer_if

// File: rtl/fsm_cycle_counter.sv
// Run-index counter: cleared on request, counts while enabled, flags the final index.
module fsm_cycle_counter #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset_async_n,
   input  logic                 i_clr,
   input  logic                 i_en,
   input  logic [CNT_WIDTH-1:0] i_limit,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic                 o_last_c
);

   logic [CNT_WIDTH-1:0] r_cnt;

   // Clear has priority; the owner clears on the exit edge so the count never wraps
   always_ff @(posedge i_clock or negedge i_reset_async_n) begin
      if (!i_reset_async_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_cnt    = r_cnt;
   // Final index of the run; gated by enable so a zero limit outside RUN never fires
   assign o_last_c = i_en && (r_cnt == (i_limit - CNT_WIDTH'(1)));

endmodule : fsm_cycle_counter

// File: rtl/fsm_run_timer.sv
// IDLE/RUN/DONE sequencer: start -> busy for N cycles -> one-cycle done pulse.
// Optional macro FSM_ABORT_EN enables i_abort (RUN -> IDLE, one-cycle o_aborted).
// Status outputs come straight from flops; o_cnt_val is the run-index register.
module fsm_run_timer #(
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned STATE_WIDTH = fsm_pkg::STATE_WIDTH
) (
   input  logic              i_clock,
   input  logic              i_reset_async_n,
   fsm_run_timer_if.slave    bus
);

   import fsm_pkg::*;

   logic [STATE_WIDTH-1:0] r_state;
   logic [STATE_WIDTH-1:0] w_state_next;
   logic [CNT_WIDTH-1:0]   r_num;
   logic [CNT_WIDTH-1:0]   w_cnt;
   logic                   w_accept;
   logic                   w_cnt_clr;
   logic                   w_cnt_en;
   logic                   w_last;
   logic                   r_idle;
   logic                   r_running;
   logic                   r_done;
`ifdef FSM_ABORT_EN
   logic                   w_abort_take;
   logic                   r_aborted;
`endif

   // State register
   always_ff @(posedge i_clock or negedge i_reset_async_n) begin
      if (!i_reset_async_n) begin
         r_state <= STATE_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and counter control
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
`ifdef FSM_ABORT_EN
      w_abort_take = 1'b0;
`endif
      case (r_state)
         STATE_IDLE: begin
            if (bus.i_isRun) begin
               w_accept     = 1'b1;
               w_state_next = (bus.i_num_cnt == '0) ? STATE_DONE : STATE_RUN;
            end
         end
         STATE_RUN: begin
`ifdef FSM_ABORT_EN
            if (bus.i_abort) begin
               w_abort_take = 1'b1;
               w_state_next = STATE_IDLE;
            end else
`endif
            if (w_last) begin
               w_state_next = STATE_DONE;
            end
         end
         STATE_DONE: begin
            w_state_next = STATE_IDLE;
         end
         default: begin
            w_state_next = STATE_IDLE;
         end
      endcase
      w_cnt_en  = (r_state == STATE_RUN);
      // Counter sits at zero whenever the next cycle is not a RUN cycle
      w_cnt_clr = (w_state_next != STATE_RUN);
   end

   // Run length latch; later i_num_cnt changes do not touch a run in progress
   always_ff @(posedge i_clock or negedge i_reset_async_n) begin
      if (!i_reset_async_n) begin
         r_num <= '0;
      end else if (w_accept) begin
         r_num <= bus.i_num_cnt;
      end
   end

   fsm_cycle_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_cycle_counter (
      .i_clock         (i_clock),
      .i_reset_async_n (i_reset_async_n),
      .i_clr           (w_cnt_clr),
      .i_en            (w_cnt_en),
      .i_limit         (r_num),
      .o_cnt           (w_cnt),
      .o_last_c        (w_last)
   );

   // Status flops loaded from the next state so they track r_state cycle for cycle
   always_ff @(posedge i_clock or negedge i_reset_async_n) begin
      if (!i_reset_async_n) begin
         r_idle    <= 1'b1;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_idle    <= (w_state_next == STATE_IDLE);
         r_running <= (w_state_next == STATE_RUN);
         r_done    <= (w_state_next == STATE_DONE);
      end
   end

`ifdef FSM_ABORT_EN
   // One-cycle abort flag covering the first IDLE cycle after an abort
   always_ff @(posedge i_clock or negedge i_reset_async_n) begin
      if (!i_reset_async_n) begin
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= w_abort_take;
      end
   end

   assign bus.o_aborted = r_aborted;
`endif

   assign bus.o_idle    = r_idle;
   assign bus.o_running = r_running;
   assign bus.o_done    = r_done;
   assign bus.o_cnt_val = w_cnt;

endmodule : fsm_run_timer

// File: tb/tb_fsm_run_timer.sv
// Directed bench for fsm_run_timer: 8-bit instance for sequencing cases,
// 4-bit instance for the full-range run. Abort cases build with FSM_ABORT_EN.
module tb_fsm_run_timer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fsm_run_timer_if #(.CNT_WIDTH(8)) if_a ();
   fsm_run_timer_if #(.CNT_WIDTH(4)) if_b ();

   fsm_run_timer #(.CNT_WIDTH(8)) u_dut_a (
      .i_clock         (clk),
      .i_reset_async_n (rst_n),
      .bus             (if_a)
   );

   fsm_run_timer #(.CNT_WIDTH(4)) u_dut_b (
      .i_clock         (clk),
      .i_reset_async_n (rst_n),
      .bus             (if_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic idle, input logic run,
                        input logic done, input logic [7:0] cnt);
      check({tag, ".idle"},    32'(if_a.o_idle),    32'(idle));
      check({tag, ".running"}, 32'(if_a.o_running), 32'(run));
      check({tag, ".done"},    32'(if_a.o_done),    32'(done));
      check({tag, ".cnt_val"}, 32'(if_a.o_cnt_val), 32'(cnt));
   endtask

   initial begin
      if_a.i_isRun = 1'b0; if_a.i_num_cnt = 8'd0;
      if_b.i_isRun = 1'b0; if_b.i_num_cnt = 4'd0;
`ifdef FSM_ABORT_EN
      if_a.i_abort = 1'b0;
      if_b.i_abort = 1'b0;
`endif

      // Reset state
      #12;
      chk_a("reset", 1'b1, 1'b0, 1'b0, 8'd0);
      check("reset_b.idle", 32'(if_b.o_idle), 32'd1);
`ifdef FSM_ABORT_EN
      check("reset.aborted", 32'(if_a.o_aborted), 32'd0);
`endif
      rst_n = 1'b1;
      tick();
      chk_a("post_reset", 1'b1, 1'b0, 1'b0, 8'd0);

      // N=5, single-cycle start pulse
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd5;
      tick();
      if_a.i_isRun = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_a($sformatf("n5_run%0d", i), 1'b0, 1'b1, 1'b0, 8'(i));
         tick();
      end
      chk_a("n5_done", 1'b0, 1'b0, 1'b1, 8'd0);
      tick();
      chk_a("n5_idle", 1'b1, 1'b0, 1'b0, 8'd0);

      // N=0 skips RUN
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd0;
      tick();
      if_a.i_isRun = 1'b0;
      chk_a("n0_done", 1'b0, 1'b0, 1'b1, 8'd0);
      tick();
      chk_a("n0_idle", 1'b1, 1'b0, 1'b0, 8'd0);

      // Held start, N=3, N changed to 7 mid-run
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd3;
      tick();
      if_a.i_num_cnt = 8'd7;
      chk_a("b2b_r0", 1'b0, 1'b1, 1'b0, 8'd0);
      tick();
      chk_a("b2b_r1", 1'b0, 1'b1, 1'b0, 8'd1);
      tick();
      chk_a("b2b_r2", 1'b0, 1'b1, 1'b0, 8'd2);
      tick();
      chk_a("b2b_done", 1'b0, 1'b0, 1'b1, 8'd0);
      if_a.i_num_cnt = 8'd3;
      tick();
      chk_a("b2b_idle", 1'b1, 1'b0, 1'b0, 8'd0);
      tick();
      chk_a("b2b_2nd_r0", 1'b0, 1'b1, 1'b0, 8'd0);
      if_a.i_isRun = 1'b0;
      tick();
      chk_a("b2b_2nd_r1", 1'b0, 1'b1, 1'b0, 8'd1);
      tick();
      chk_a("b2b_2nd_r2", 1'b0, 1'b1, 1'b0, 8'd2);
      tick();
      chk_a("b2b_2nd_done", 1'b0, 1'b0, 1'b1, 8'd0);
      tick();
      chk_a("b2b_2nd_idle", 1'b1, 1'b0, 1'b0, 8'd0);

      // Reset mid-run, N=10, at index 4
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd10;
      tick();
      if_a.i_isRun = 1'b0;
      repeat (4) tick();
      chk_a("rst_mid_pre", 1'b0, 1'b1, 1'b0, 8'd4);
      rst_n = 1'b0;
      #1;
      chk_a("rst_mid_async", 1'b1, 1'b0, 1'b0, 8'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("rst_mid_nodone%0d", i), 32'(if_a.o_done), 32'd0);
      end
      chk_a("rst_mid_idle", 1'b1, 1'b0, 1'b0, 8'd0);

      // CNT_WIDTH=4, N=15: full index range, no wrap
      if_b.i_isRun = 1'b1; if_b.i_num_cnt = 4'd15;
      tick();
      if_b.i_isRun = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check($sformatf("w4_run%0d", i), 32'(if_b.o_running), 32'd1);
         check($sformatf("w4_cnt%0d", i), 32'(if_b.o_cnt_val), 32'(i));
         tick();
      end
      check("w4_done",      32'(if_b.o_done),    32'd1);
      check("w4_done_cnt",  32'(if_b.o_cnt_val), 32'd0);
      check("w4_done_run",  32'(if_b.o_running), 32'd0);
      tick();
      check("w4_idle",      32'(if_b.o_idle),    32'd1);

`ifdef FSM_ABORT_EN
      // Abort in IDLE is ignored
      if_a.i_abort = 1'b1;
      tick();
      if_a.i_abort = 1'b0;
      check("ab_idle_ign", 32'(if_a.o_aborted), 32'd0);
      chk_a("ab_idle_state", 1'b1, 1'b0, 1'b0, 8'd0);

      // N=8, abort at index 3
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd8;
      tick();
      if_a.i_isRun = 1'b0;
      repeat (3) tick();
      chk_a("ab3_pre", 1'b0, 1'b1, 1'b0, 8'd3);
      if_a.i_abort = 1'b1;
      tick();
      if_a.i_abort = 1'b0;
      chk_a("ab3_post", 1'b1, 1'b0, 1'b0, 8'd0);
      check("ab3_aborted", 32'(if_a.o_aborted), 32'd1);
      tick();
      check("ab3_aborted_clr", 32'(if_a.o_aborted), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ab3_nodone%0d", i), 32'(if_a.o_done), 32'd0);
         tick();
      end

      // N=8, abort on the index-7 edge wins over completion
      if_a.i_isRun = 1'b1; if_a.i_num_cnt = 8'd8;
      tick();
      if_a.i_isRun = 1'b0;
      repeat (7) tick();
      chk_a("ab7_pre", 1'b0, 1'b1, 1'b0, 8'd7);
      if_a.i_abort = 1'b1;
      tick();
      if_a.i_abort = 1'b0;
      chk_a("ab7_post", 1'b1, 1'b0, 1'b0, 8'd0);
      check("ab7_aborted", 32'(if_a.o_aborted), 32'd1);
      tick();
      check("ab7_aborted_clr", 32'(if_a.o_aborted), 32'd0);
      check("ab7_nodone", 32'(if_a.o_done), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fsm_run_timer
